// File: rtl/mux4_rr_sched.sv
// ============================================================================
// mux4_rr_sched : round-robin grant scheduler for a 4:1 tristate-capable mux
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module mux4_rr_sched #(
   parameter int DWELL = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic       done,
   output logic [1:0] sel,
   output logic       enable,
   output logic [3:0] grant,
   output logic       timeout
);

   localparam logic [3:0] c_dwell = 4'(DWELL);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t     r_state, w_state_nxt;
   logic [1:0] r_ptr, w_ptr_nxt;
   logic [1:0] r_sel, w_sel_nxt;
   logic [3:0] r_cnt, w_cnt_nxt;
   logic       r_enable, w_enable_nxt;
   logic [3:0] r_grant, w_grant_nxt;
   logic       r_timeout, w_timeout_nxt;

   logic [7:0] w_req2;
   logic [7:0] w_rot;
   logic [1:0] w_off;
   logic       w_any;
   logic [1:0] w_win;

   // Rotate requests so bit 0 is the source just after the last winner.
   always_comb begin
      w_req2 = {req, req};
      w_rot  = w_req2 >> ({1'b0, r_ptr} + 3'd1);
      w_any  = |req;
      w_off  = 2'd0;
      casez (w_rot[3:0])
         4'b???1: w_off = 2'd0;
         4'b??10: w_off = 2'd1;
         4'b?100: w_off = 2'd2;
         4'b1000: w_off = 2'd3;
         default: w_off = 2'd0;
      endcase
      w_win = r_ptr + 2'd1 + w_off;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_ptr_nxt     = r_ptr;
      w_sel_nxt     = r_sel;
      w_cnt_nxt     = r_cnt;
      w_enable_nxt  = 1'b0;
      w_timeout_nxt = 1'b0;
      case (r_state)
         S_IDLE, S_GAP: begin
            if (w_any) begin
               w_state_nxt  = S_GRANT;
               w_sel_nxt    = w_win;
               w_ptr_nxt    = w_win;
               w_cnt_nxt    = 4'd1;
               w_enable_nxt = 1'b1;
            end else begin
               w_state_nxt  = S_IDLE;
            end
         end
         S_GRANT: begin
            if (done || !req[r_sel]) begin
               w_state_nxt   = S_GAP;
            end else if (r_cnt == c_dwell) begin
               w_state_nxt   = S_GAP;
               w_timeout_nxt = 1'b1;
            end else begin
               w_cnt_nxt     = r_cnt + 4'd1;
               w_enable_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      w_grant_nxt = w_enable_nxt ? (4'b0001 << w_sel_nxt) : 4'b0000;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_ptr     <= 2'd3;
         r_sel     <= 2'd0;
         r_cnt     <= 4'd0;
         r_enable  <= 1'b0;
         r_grant   <= 4'b0000;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_ptr     <= w_ptr_nxt;
         r_sel     <= w_sel_nxt;
         r_cnt     <= w_cnt_nxt;
         r_enable  <= w_enable_nxt;
         r_grant   <= w_grant_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   assign sel     = r_sel;
   assign enable  = r_enable;
   assign grant   = r_grant;
   assign timeout = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_mux4_rr_sched.sv
// ============================================================================
// tb_mux4_rr_sched : scoreboard bench for mux4_rr_sched against a spec model
// Rev 1.0          : initial release
// ============================================================================
`default_nettype none

module tb_mux4_rr_sched;

   localparam int DWELL = 4;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic       done;
   logic [1:0] sel;
   logic       enable;
   logic [3:0] grant;
   logic       timeout;

   mux4_rr_sched #(.DWELL(DWELL)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .done    (done),
      .sel     (sel),
      .enable  (enable),
      .grant   (grant),
      .timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] sel;
      logic       en;
      logic [3:0] gnt;
      logic       to;
   } exp_t;

   exp_t q_exp[$];
   int   n_pass  = 0;
   int   n_total = 0;
   int   n_cycle = 0;

   // Reference model: who owns the mux, how long, who was served last.
   int         m_owner;
   int         m_age;
   int         m_last;
   logic [1:0] m_sel;
   logic       m_to;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s cycle=%0d got=%h expected=%h", name, n_cycle, got, exp);
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_age   = 0;
      m_last  = 3;
      m_sel   = 2'd0;
      m_to    = 1'b0;
   endtask

   task automatic model_step(input logic rstn, input logic [3:0] rq, input logic dn);
      exp_t e;
      if (!rstn) begin
         model_reset();
      end else if (m_owner >= 0) begin
         if (dn || !rq[m_owner]) begin
            m_owner = -1;
            m_to    = 1'b0;
         end else if (m_age == DWELL) begin
            m_owner = -1;
            m_to    = 1'b1;
         end else begin
            m_age++;
         end
      end else begin
         m_to = 1'b0;
         for (int i = 1; i <= 4; i++) begin
            int c;
            c = (m_last + i) % 4;
            if (rq[c]) begin
               m_owner = c;
               m_last  = c;
               m_sel   = c[1:0];
               m_age   = 1;
               break;
            end
         end
      end
      e.sel = m_sel;
      e.en  = (m_owner >= 0);
      e.gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      e.to  = m_to;
      q_exp.push_back(e);
   endtask

   task automatic step(input logic rstn, input logic [3:0] rq, input logic dn);
      @(negedge clk);
      rst_n = rstn;
      req   = rq;
      done  = dn;
      model_step(rstn, rq, dn);
   endtask

   // Monitor: every rising edge produces one output word to score.
   initial begin
      exp_t e;
      exp_t got;
      forever begin
         @(posedge clk);
         #1;
         n_cycle++;
         if (q_exp.size() > 0) begin
            e   = q_exp.pop_front();
            got = {sel, enable, grant, timeout};
            chk("scoreboard", 32'(got), 32'(e));
         end
      end
   end

   initial begin
      logic [3:0] r_req;
      logic       dropped;
      rst_n = 1'b0;
      req   = 4'b0000;
      done  = 1'b0;
      model_reset();

      // Reset, then idle with no requests.
      repeat (3) step(1'b0, 4'b0000, 1'b0);
      repeat (10) step(1'b1, 4'b0000, 1'b0);

      // Single requester, done on its second grant cycle.
      repeat (12) step(1'b1, 4'b0100, (m_owner >= 0 && m_age == 2));
      step(1'b1, 4'b0000, 1'b0);
      step(1'b1, 4'b0000, 1'b0);

      // All requesting, done every grant cycle.
      repeat (12) step(1'b1, 4'b1111, (m_owner >= 0));
      step(1'b1, 4'b0000, 1'b0);
      step(1'b1, 4'b0000, 1'b0);

      // Dwell expiry, then done landing on the final dwell cycle.
      repeat (8) step(1'b1, 4'b0001, 1'b0);
      repeat (8) step(1'b1, 4'b0001, (m_owner >= 0 && m_age == DWELL));

      // Source 3 withdraws on its second cycle while source 1 waits.
      for (int i = 0; i < 10 && m_owner != 3; i++) step(1'b1, 4'b1000, 1'b0);
      dropped = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (m_owner == 3 && m_age == 2) dropped = 1'b1;
         step(1'b1, dropped ? 4'b0010 : 4'b1010, 1'b0);
      end

      // Asynchronous reset in the middle of a grant to source 2.
      for (int i = 0; i < 10 && m_owner != 2; i++) step(1'b1, 4'b0100, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      req   = 4'b0110;
      done  = 1'b0;
      #1;
      chk("rst_async_enable",  32'(enable),  32'd0);
      chk("rst_async_sel",     32'(sel),     32'd0);
      chk("rst_async_grant",   32'(grant),   32'd0);
      chk("rst_async_timeout", 32'(timeout), 32'd0);
      model_step(1'b0, 4'b0110, 1'b0);
      step(1'b0, 4'b0110, 1'b0);
      step(1'b1, 4'b0110, 1'b0);
      @(posedge clk);
      #2;
      chk("rst_first_grant", 32'(grant), 32'b0010);

      // Randomised traffic with occasional resets.
      r_req = 4'b0000;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) r_req = 4'($urandom_range(0, 15));
         step(($urandom_range(0, 399) != 0), r_req, ($urandom_range(0, 3) == 0));
      end
      step(1'b1, 4'b0000, 1'b0);

      for (int i = 0; i < 5 && q_exp.size() > 0; i++) @(posedge clk);
      #2;
      chk("queue_drained", 32'(q_exp.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
